// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl: responder end of the cache-to-memory interface.
// Serves word requests from the dcache (read/write) and the icache (read)
// over one single-ported RAM. The dcache normally wins arbitration, but the
// icache is forced through after STARVE_MAX back-to-back data grants. A RAM
// access that sees neither ACCESS nor ERROR within TIMEOUT cycles is aborted,
// and the waiting cache receives ERR_WORD.
//
// Ports
//   CLK, nRST                  clock, asynchronous active-low reset
//   dREN, dWEN, daddr, dstore  dcache request (both strobes set = write)
//   dwait, dload               dcache completion (dwait low one cycle) and data
//   iREN, iaddr                icache fetch request
//   iwait, iload               icache completion (iwait low one cycle) and data
//   ramREN, ramWEN, ramaddr,
//   ramstore                   RAM request
//   ramstate, ramload          RAM status (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR), data
//   ccerr                      one-cycle pulse on RAM timeout or RAM error
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no access in flight; arbitration point between every word
// DACC  | dcache word on the RAM, waiting for ACCESS
// IACC  | icache word on the RAM, waiting for ACCESS
// ERR   | one-cycle error completion to the requester recorded in err_dsrc

module cache_mem_ctrl #(
   parameter int unsigned TIMEOUT    = 16,
   parameter int unsigned STARVE_MAX = 4,
   parameter logic [31:0] ERR_WORD   = 32'hBAD1BAD1
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [1:0]  ramstate,
   input  logic [31:0] ramload,
   output logic        ccerr
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
   localparam logic [1:0]    RAM_ACCESS = 2'd2;
   localparam logic [1:0]    RAM_ERROR  = 2'd3;

   typedef enum logic [1:0] {IDLE, DACC, IACC, ERR} state_t;

   state_t        state, next_state;
   logic [TW-1:0] tcnt, next_tcnt;
   logic [SW-1:0] starve_cnt, next_starve;
   logic          err_dsrc, next_err_dsrc;
   logic          dreq;

   assign dreq = dREN | dWEN;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         tcnt       <= '0;
         starve_cnt <= '0;
         err_dsrc   <= 1'b0;
      end else begin
         state      <= next_state;
         tcnt       <= next_tcnt;
         starve_cnt <= next_starve;
         err_dsrc   <= next_err_dsrc;
      end
   end

   always_comb begin
      next_state    = state;
      next_tcnt     = tcnt;
      next_starve   = starve_cnt;
      next_err_dsrc = err_dsrc;
      dwait         = 1'b1;
      dload         = '0;
      iwait         = 1'b1;
      iload         = '0;
      ramREN        = 1'b0;
      ramWEN        = 1'b0;
      ramaddr       = '0;
      ramstore      = '0;
      ccerr         = 1'b0;

      case (state)
         IDLE: begin
            next_tcnt = '0;
            if (!iREN)
               next_starve = '0;
            if (iREN && starve_cnt == STARVE_TOP)
               next_state = IACC;
            else if (dreq)
               next_state = DACC;
            else if (iREN)
               next_state = IACC;
         end

         DACC: begin
            // A requester that lets go abandons the word silently.
            if (!dreq) begin
               next_state = IDLE;
            end else begin
               ramaddr  = daddr;
               ramstore = dstore;
               ramWEN   = dWEN;
               ramREN   = dREN & ~dWEN;
               if (ramstate == RAM_ACCESS) begin
                  dwait      = 1'b0;
                  dload      = dWEN ? '0 : ramload;
                  next_state = IDLE;
                  if (iREN && starve_cnt != STARVE_TOP)
                     next_starve = starve_cnt + 1'b1;
               end else if (ramstate == RAM_ERROR || tcnt == TCNT_LAST) begin
                  next_state    = ERR;
                  next_err_dsrc = 1'b1;
               end else begin
                  next_tcnt = tcnt + 1'b1;
               end
            end
         end

         IACC: begin
            if (!iREN) begin
               next_state = IDLE;
            end else begin
               ramaddr = iaddr;
               ramREN  = 1'b1;
               if (ramstate == RAM_ACCESS) begin
                  iwait       = 1'b0;
                  iload       = ramload;
                  next_state  = IDLE;
                  next_starve = '0;
               end else if (ramstate == RAM_ERROR || tcnt == TCNT_LAST) begin
                  next_state    = ERR;
                  next_err_dsrc = 1'b0;
               end else begin
                  next_tcnt = tcnt + 1'b1;
               end
            end
         end

         ERR: begin
            ccerr      = 1'b1;
            next_state = IDLE;
            if (err_dsrc) begin
               dwait = 1'b0;
               dload = ERR_WORD;
            end else begin
               // A failed fetch still counts as the icache having had its turn.
               iwait       = 1'b0;
               iload       = ERR_WORD;
               next_starve = '0;
            end
         end

         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
module tb_cache_mem_ctrl;

   localparam logic [31:0] ERR_WORD = 32'hBAD1BAD1;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        dREN, dWEN, iREN;
   logic [31:0] daddr, dstore, iaddr;
   logic        dwait, iwait, ramREN, ramWEN, ccerr;
   logic [31:0] dload, iload, ramaddr, ramstore, ramload;
   logic [1:0]  ramstate;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;

   typedef struct packed {
      logic        is_d;
      logic [31:0] load;
      logic        err;
   } exp_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   exp_t exp_q[$];
   wr_t  wr_q[$];
   exp_t mon_e;
   wr_t  wr_e;

   // RAM model: mode 0 answers after ram_lat busy cycles, 1 stays BUSY, 2 reports ERROR.
   logic [31:0] mem [0:255];
   logic [1:0]  ram_mode = 2'd0;
   logic [7:0]  ram_lat  = 8'd2;
   logic [7:0]  rcnt;
   logic        strobe;

   always #5 CLK = ~CLK;

   cache_mem_ctrl dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dwait    (dwait),
      .dload    (dload),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramstate (ramstate),
      .ramload  (ramload),
      .ccerr    (ccerr)
   );

   assign strobe   = ramREN | ramWEN;
   assign ramstate = !strobe             ? 2'd0 :
                     (ram_mode == 2'd1)  ? 2'd1 :
                     (ram_mode == 2'd2)  ? 2'd3 :
                     (rcnt == ram_lat)   ? 2'd2 : 2'd1;
   assign ramload  = mem[ramaddr[9:2]];

   always @(posedge CLK or negedge nRST) begin
      if (!nRST)
         rcnt <= 8'd0;
      else if (!strobe || ramstate == 2'd2)
         rcnt <= 8'd0;
      else
         rcnt <= rcnt + 8'd1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic is_d, input logic [31:0] load, input logic err);
      exp_t e;
      e.is_d = is_d;
      e.load = load;
      e.err  = err;
      exp_q.push_back(e);
   endtask

   task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
      wr_t w;
      w.addr = addr;
      w.data = data;
      wr_q.push_back(w);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(posedge CLK);
         n++;
      end
      #1;
      check("wait_done", 32'(done_cnt), 32'(target));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_dwait"},    32'(dwait),  32'd1);
      check({tag, "_iwait"},    32'(iwait),  32'd1);
      check({tag, "_dload"},    dload,       32'd0);
      check({tag, "_iload"},    iload,       32'd0);
      check({tag, "_ramREN"},   32'(ramREN), 32'd0);
      check({tag, "_ramWEN"},   32'(ramWEN), 32'd0);
      check({tag, "_ramaddr"},  ramaddr,     32'd0);
      check({tag, "_ramstore"}, ramstore,    32'd0);
      check({tag, "_ccerr"},    32'(ccerr),  32'd0);
   endtask

   // Called at posedge+1 with the controller in IDLE; RAM latency 2.
   task automatic single_read(input logic [31:0] addr);
      push_exp(1'b1, mem[addr[9:2]], 1'b0);
      dREN  = 1'b1;
      daddr = addr;
      @(negedge CLK);
      check("rd_idle_ramREN",  32'(ramREN), 32'd0);
      check("rd_idle_ramaddr", ramaddr,     32'd0);
      @(negedge CLK);
      check("rd_c1_ramREN",  32'(ramREN), 32'd1);
      check("rd_c1_ramWEN",  32'(ramWEN), 32'd0);
      check("rd_c1_ramaddr", ramaddr,     addr);
      check("rd_c1_dwait",   32'(dwait),  32'd1);
      @(negedge CLK);
      check("rd_c2_ramREN", 32'(ramREN), 32'd1);
      check("rd_c2_dwait",  32'(dwait),  32'd1);
      @(negedge CLK);
      check("rd_c3_dwait", 32'(dwait), 32'd0);
      @(posedge CLK);
      #1;
      dREN = 1'b0;
   endtask

   // Counts strobe cycles until the requester's wait drops; returns count and strobe at completion.
   task automatic count_to_done(input logic is_d, output int cnt, output logic str_at_done);
      int n = 0;
      cnt = 0;
      str_at_done = 1'b1;
      while (n < 100) begin
         @(negedge CLK);
         n++;
         if ((is_d && !dwait) || (!is_d && !iwait)) begin
            str_at_done = strobe;
            break;
         end
         if (strobe) cnt++;
      end
      @(posedge CLK);
      #1;
   endtask

   // Response monitor: every wait=0 / ccerr cycle must match the head of the scoreboard.
   always @(negedge CLK) begin
      if (nRST && (!dwait || !iwait || ccerr)) begin
         check("wait_exclusive", 32'(!dwait && !iwait), 32'd0);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_response dwait=%b iwait=%b ccerr=%b required=no response at %0t",
                     dwait, iwait, ccerr, $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("resp_source", 32'(!dwait), 32'(mon_e.is_d));
            check("resp_load",   mon_e.is_d ? dload : iload, mon_e.load);
            check("resp_ccerr",  32'(ccerr), 32'(mon_e.err));
            done_cnt++;
         end
      end
   end

   // Write monitor: each completed RAM write must match the expected write stream.
   always @(negedge CLK) begin
      if (nRST && ramWEN && ramstate == 2'd2) begin
         if (wr_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write addr=%h data=%h required=no write", ramaddr, ramstore);
         end else begin
            wr_e = wr_q.pop_front();
            check("wr_addr", ramaddr,  wr_e.addr);
            check("wr_data", ramstore, wr_e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cnt;
      logic str;
      int   base;

      dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
      daddr = '0; dstore = '0; iaddr = '0;
      for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
      mem[8'h40] = 32'h12345678;

      #2;
      check_reset_outputs("rst");
      repeat (2) @(posedge CLK);
      #1;
      nRST = 1'b1;
      step();

      // Single data read, latency 2.
      single_read(32'h100);
      step();

      // Simultaneous requests: data first, then the fetch after the IDLE cycle.
      base = done_cnt;
      push_exp(1'b1, mem[8'h0C], 1'b0);
      push_exp(1'b0, mem[8'h10], 1'b0);
      dREN = 1'b1; daddr = 32'h30;
      iREN = 1'b1; iaddr = 32'h40;
      wait_done(base + 1, 20);
      dREN = 1'b0;
      wait_done(base + 2, 20);
      iREN = 1'b0;
      step();

      // Starvation: four data words, one forced fetch, then data again.
      base = done_cnt;
      for (int k = 0; k < 4; k++) push_exp(1'b1, mem[8'h04], 1'b0);
      push_exp(1'b0, mem[8'h08], 1'b0);
      push_exp(1'b1, mem[8'h04], 1'b0);
      dREN = 1'b1; daddr = 32'h10;
      iREN = 1'b1; iaddr = 32'h20;
      wait_done(base + 6, 60);
      dREN = 1'b0; iREN = 1'b0;
      step();

      // Writeback pair; second word also raises dREN, which must still write.
      base = done_cnt;
      push_exp(1'b1, 32'd0, 1'b0);
      push_exp(1'b1, 32'd0, 1'b0);
      push_wr(32'h200, 32'hA);
      push_wr(32'h204, 32'hB);
      dWEN = 1'b1; daddr = 32'h200; dstore = 32'hA;
      wait_done(base + 1, 20);
      dREN = 1'b1; daddr = 32'h204; dstore = 32'hB;
      @(negedge CLK);
      @(negedge CLK);
      check("wb2_ramREN", 32'(ramREN), 32'd0);
      check("wb2_ramWEN", 32'(ramWEN), 32'd1);
      wait_done(base + 2, 20);
      dWEN = 1'b0; dREN = 1'b0;
      step();

      // Timeout with RAM stuck BUSY.
      ram_mode = 2'd1;
      push_exp(1'b1, ERR_WORD, 1'b1);
      dREN = 1'b1; daddr = 32'h300;
      count_to_done(1'b1, cnt, str);
      dREN = 1'b0;
      check("timeout_cycles", 32'(cnt), 32'd16);
      check("timeout_err_strobe", 32'(str), 32'd0);
      step();

      // RAM ERROR on a data word.
      ram_mode = 2'd2;
      push_exp(1'b1, ERR_WORD, 1'b1);
      dREN = 1'b1; daddr = 32'h304;
      count_to_done(1'b1, cnt, str);
      dREN = 1'b0;
      check("ramerr_d_cycles", 32'(cnt), 32'd1);
      check("ramerr_d_strobe", 32'(str), 32'd0);
      step();

      // RAM ERROR on a fetch.
      push_exp(1'b0, ERR_WORD, 1'b1);
      iREN = 1'b1; iaddr = 32'h308;
      count_to_done(1'b0, cnt, str);
      iREN = 1'b0;
      check("ramerr_i_cycles", 32'(cnt), 32'd1);
      step();

      // Abort: drop dREN mid-DACC.
      ram_mode = 2'd1;
      dREN = 1'b1; daddr = 32'h400;
      step(); step(); step();
      dREN = 1'b0;
      @(negedge CLK);
      check("abort_ramREN", 32'(ramREN), 32'd0);
      check("abort_ramWEN", 32'(ramWEN), 32'd0);
      check("abort_dwait",  32'(dwait),  32'd1);
      check("abort_ccerr",  32'(ccerr),  32'd0);
      step(); step();
      ram_mode = 2'd0;
      single_read(32'h100);
      step();

      // Reset asserted mid-IACC.
      ram_mode = 2'd1;
      iREN = 1'b1; iaddr = 32'h500;
      step(); step();
      check("iacc_ramaddr", ramaddr, 32'h500);
      #2;
      nRST = 1'b0;
      #1;
      check_reset_outputs("midrst");
      iREN = 1'b0;
      ram_mode = 2'd0;
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      step();
      single_read(32'h100);
      step(); step();

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check("wr_q_drained",  32'(wr_q.size()),  32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
